memoria_dados_resp: RTL

// Data-memory responder for the nRisc core: the target end of the core's data-memory port.

---
 rtl/memoria_dados_resp_pkg.sv | 24 ++
 rtl/memoria_dados_resp_banco_memoria.sv | 25 ++
 rtl/memoria_dados_resp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/memoria_dados_resp_pkg.sv
// Shared definitions for the nRisc data-memory responder: default width,
// FSM state codes and the wait-counter preset helper.
package memoria_dados_resp_pkg;

  localparam int LARGURA_PADRAO = 8;
  localparam int LARGURA_CNT    = 4;

  // 2'd3 is not a legal state; the FSM falls back to OCIOSO from it.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  // Value loaded into the wait counter when a request is accepted.
  function automatic logic [LARGURA_CNT-1:0] cnt_inicial(input int latencia);
    if (latencia > 0) begin
      return LARGURA_CNT'(latencia - 1);
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/memoria_dados_resp_banco_memoria.sv
// Storage array: PROFUNDIDADE words of LARGURA bits, synchronous write,
// registered read, no reset (contents undefined after power-up).
module banco_memoria #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 256,
  parameter int LARG_END     = 8
) (
  input  logic                Clock,
  input  logic                we,
  input  logic [LARG_END-1:0] addr,
  input  logic [LARGURA-1:0]  din,
  output logic [LARGURA-1:0]  dout
);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];

  // Write port and registered read port; a read during a write returns the old word.
  always_ff @(posedge Clock) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/memoria_dados_resp.sv
// Data-memory responder for the nRisc core. Accepts one read or write at a
// time, waits LATENCIA cycles, then completes with a one-cycle Pronto pulse.
module memoria_dados_resp
  import memoria_dados_resp_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = 256,
  parameter int LATENCIA     = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Req,
  input  logic               Escrita,
  input  logic [LARGURA-1:0] Endereco,
  input  logic [LARGURA-1:0] DadoEscrito,
  output logic [LARGURA-1:0] DadoLido,
  output logic               Pronto,
  output logic               Ocupado,
  output logic               Erro
);

  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [LARGURA_CNT-1:0] CNT_INI = cnt_inicial(LATENCIA);

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic                   w_executa;
  logic [LARGURA_CNT-1:0] r_cnt;
  logic                   r_escrita;
  logic [LARGURA-1:0]     r_addr;
  logic [LARGURA-1:0]     r_dado;
  logic                   w_sel_entrada;
  logic                   w_acc_escrita;
  logic [LARGURA-1:0]     w_acc_addr;
  logic [LARGURA-1:0]     w_acc_dado;
  logic                   w_fora;
  logic                   w_we;
  logic [LARGURA-1:0]     w_dout;
  logic                   r_erro;
  logic                   r_usa_banco;
  logic [LARGURA-1:0]     r_dado_lido;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state logic; w_executa marks the edge that enters RESPONDE.
  always_comb begin
    w_prox_estado = r_estado;
    w_executa     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (Req) begin
          if (LATENCIA == 0) begin
            w_prox_estado = RESPONDE;
            w_executa     = 1'b1;
          end else begin
            w_prox_estado = ESPERA;
          end
        end else begin
          w_prox_estado = OCIOSO;
        end
      end
      ESPERA: begin
        if (r_cnt == '0) begin
          w_prox_estado = RESPONDE;
          w_executa     = 1'b1;
        end else begin
          w_prox_estado = ESPERA;
        end
      end
      RESPONDE: begin
        w_prox_estado = OCIOSO;
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // Op registers and wait counter: latch the request in OCIOSO, count down in ESPERA.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_escrita <= 1'b0;
      r_addr    <= '0;
      r_dado    <= '0;
    end else if (r_estado == OCIOSO && Req) begin
      r_cnt     <= CNT_INI;
      r_escrita <= Escrita;
      r_addr    <= Endereco;
      r_dado    <= DadoEscrito;
    end else if (r_estado == ESPERA && r_cnt != '0) begin
      r_cnt <= r_cnt - LARGURA_CNT'(1);
    end
  end

  // With zero latency the access runs on the accepting edge, so the live
  // inputs feed the array while idle; otherwise the latched op is used.
  assign w_sel_entrada = (r_estado == OCIOSO);
  assign w_acc_escrita = w_sel_entrada ? Escrita     : r_escrita;
  assign w_acc_addr    = w_sel_entrada ? Endereco    : r_addr;
  assign w_acc_dado    = w_sel_entrada ? DadoEscrito : r_dado;

  generate
    if (PROFUNDIDADE >= (1 << LARGURA)) begin : g_sem_faixa
      assign w_fora = 1'b0;
    end else begin : g_com_faixa
      assign w_fora = (w_acc_addr >= LARGURA'(PROFUNDIDADE));
    end
  endgenerate

  // Out-of-range writes are dropped; a reset edge never commits a write.
  assign w_we = w_executa & w_acc_escrita & ~w_fora & ~Reset;

  banco_memoria #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_END     (AW)
  ) u_banco (
    .Clock (Clock),
    .we    (w_we),
    .addr  (w_acc_addr[AW-1:0]),
    .din   (w_acc_dado),
    .dout  (w_dout)
  );

  // Response registers: the array's registered read is valid during RESPONDE
  // and is captured on leaving it so DadoLido holds until the next access.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_erro      <= 1'b0;
      r_usa_banco <= 1'b0;
      r_dado_lido <= '0;
    end else if (w_executa) begin
      r_erro      <= w_fora;
      r_usa_banco <= ~w_acc_escrita & ~w_fora;
      r_dado_lido <= '0;
    end else if (r_estado == RESPONDE) begin
      r_usa_banco <= 1'b0;
      if (r_usa_banco) begin
        r_dado_lido <= w_dout;
      end else begin
        r_dado_lido <= r_dado_lido;
      end
    end
  end

  assign DadoLido = r_usa_banco ? w_dout : r_dado_lido;
  assign Erro     = r_erro;
  assign Pronto   = (r_estado == RESPONDE);
  assign Ocupado  = (r_estado != OCIOSO);

endmodule
